// File: rtl/demux_buffer.sv
// demux_buffer: registered 1-to-2 demultiplexer with valid/ready handshaking
// and an independent 2-entry FIFO per output channel.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   in_data/in_valid/sw      producer word, its valid, channel select (0=A, 1=B)
//   in_ready                 selected channel has room (combinational from sw)
//   a_data/a_valid/a_ready   channel A head word, non-empty flag, consumer take
//   b_data/b_valid/b_ready   channel B head word, non-empty flag, consumer take

// Two-slot FIFO used for each output channel. No same-cycle pass-through, so a
// full FIFO stays full for the cycle in which it pops.
module demux_buffer_fifo #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNT_W = 2;

  logic [WIDTH-1:0] slot [DEPTH];
  logic             wptr;
  logic             rptr;
  logic [CNT_W-1:0] count;
  logic             pop;

  // Pops on an empty FIFO are ignored.
  assign pop   = valid & pop_ready;
  assign valid = (count != '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign data  = slot[rptr];

  // Storage, pointers and occupancy; reset clears everything including slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot[i] <= '0;
      end
    end else begin
      if (push) begin
        slot[wptr] <= push_data;
        wptr       <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

module demux_buffer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             sw,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready
);

  logic a_full;
  logic b_full;
  logic accept;
  logic a_push;
  logic b_push;

  // Ready reflects only the selected channel's room; independent of in_valid.
  assign in_ready = sw ? ~b_full : ~a_full;
  assign accept   = in_valid & in_ready;
  assign a_push   = accept & ~sw;
  assign b_push   = accept & sw;

  demux_buffer_fifo #(.WIDTH(WIDTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (a_push),
    .push_data (in_data),
    .pop_ready (a_ready),
    .full      (a_full),
    .valid     (a_valid),
    .data      (a_data)
  );

  demux_buffer_fifo #(.WIDTH(WIDTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (b_push),
    .push_data (in_data),
    .pop_ready (b_ready),
    .full      (b_full),
    .valid     (b_valid),
    .data      (b_data)
  );

endmodule

// File: tb/tb_demux_buffer.sv
// Directed, table-driven bench for demux_buffer: each record gives the inputs
// for one cycle, the in_ready expected before the edge, and the channel
// outputs expected after it. Data is compared only where valid is expected.
module tb_demux_buffer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NVEC  = 20;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             sw;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             sw;
    logic [WIDTH-1:0] din;
    logic             vld;
    logic             ar;
    logic             br;
    logic             exp_rdy;
    logic             exp_av;
    logic [WIDTH-1:0] exp_ad;
    logic             exp_bv;
    logic [WIDTH-1:0] exp_bd;
  } vec_t;

  vec_t vecs [NVEC];

  demux_buffer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .sw       (sw),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic [WIDTH-1:0] d, input logic v,
                              input logic ar, input logic br, input logic rdy,
                              input logic av, input logic [WIDTH-1:0] ad,
                              input logic bv, input logic [WIDTH-1:0] bd);
    vec_t r;
    r.sw = s; r.din = d; r.vld = v; r.ar = ar; r.br = br;
    r.exp_rdy = rdy; r.exp_av = av; r.exp_ad = ad; r.exp_bv = bv; r.exp_bd = bd;
    return r;
  endfunction

  initial begin
    //           sw  din    vld ar  br  rdy  av  ad     bv  bd
    // route to A, fill A, overflow attempt
    vecs[0]  = mk(0, 4'h3, 1, 0, 0, 1,   1, 4'h3, 0, 4'h0);
    vecs[1]  = mk(0, 4'hC, 1, 0, 0, 1,   1, 4'h3, 0, 4'h0);
    vecs[2]  = mk(0, 4'hF, 1, 0, 0, 0,   1, 4'h3, 0, 4'h0);
    // B accepts while A is full
    vecs[3]  = mk(1, 4'h5, 1, 0, 0, 1,   1, 4'h3, 1, 4'h5);
    // drain A in order; third pop on empty has no effect
    vecs[4]  = mk(0, 4'h0, 0, 1, 0, 0,   1, 4'hC, 1, 4'h5);
    vecs[5]  = mk(0, 4'h0, 0, 1, 0, 1,   0, 4'h0, 1, 4'h5);
    vecs[6]  = mk(0, 4'h0, 0, 1, 0, 1,   0, 4'h0, 1, 4'h5);
    // stream into B with simultaneous pop
    vecs[7]  = mk(1, 4'h1, 1, 0, 1, 1,   0, 4'h0, 1, 4'h1);
    vecs[8]  = mk(1, 4'h2, 1, 0, 1, 1,   0, 4'h0, 1, 4'h2);
    vecs[9]  = mk(1, 4'h3, 1, 0, 1, 1,   0, 4'h0, 1, 4'h3);
    vecs[10] = mk(1, 4'h4, 1, 0, 1, 1,   0, 4'h0, 1, 4'h4);
    vecs[11] = mk(1, 4'h0, 0, 0, 1, 1,   0, 4'h0, 0, 4'h0);
    // fill both channels after pointers have wrapped
    vecs[12] = mk(0, 4'h6, 1, 0, 0, 1,   1, 4'h6, 0, 4'h0);
    vecs[13] = mk(0, 4'h7, 1, 0, 0, 1,   1, 4'h6, 0, 4'h0);
    vecs[14] = mk(1, 4'h8, 1, 0, 0, 1,   1, 4'h6, 1, 4'h8);
    vecs[15] = mk(1, 4'h9, 1, 0, 0, 1,   1, 4'h6, 1, 4'h8);
    vecs[16] = mk(1, 4'hA, 1, 0, 0, 0,   1, 4'h6, 1, 4'h8);
    vecs[17] = mk(0, 4'hA, 1, 0, 0, 0,   1, 4'h6, 1, 4'h8);
    // full B popping in the same cycle still refuses the push
    vecs[18] = mk(1, 4'hB, 1, 0, 1, 0,   1, 4'h6, 1, 4'h9);
    vecs[19] = mk(1, 4'hD, 1, 0, 0, 1,   1, 4'h6, 1, 4'h9);

    rst = 1'b1; in_data = '0; in_valid = 1'b0; sw = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset a_valid", 32'(a_valid), 32'd0);
    check("reset b_valid", 32'(b_valid), 32'd0);
    check("reset a_data", 32'(a_data), 32'd0);
    check("reset b_data", 32'(b_data), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < int'(NVEC); i++) begin
      @(negedge clk);
      sw = vecs[i].sw; in_data = vecs[i].din; in_valid = vecs[i].vld;
      a_ready = vecs[i].ar; b_ready = vecs[i].br;
      #1;
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d a_valid", i), 32'(a_valid), 32'(vecs[i].exp_av));
      check($sformatf("v%0d b_valid", i), 32'(b_valid), 32'(vecs[i].exp_bv));
      if (vecs[i].exp_av) check($sformatf("v%0d a_data", i), 32'(a_data), 32'(vecs[i].exp_ad));
      if (vecs[i].exp_bv) check($sformatf("v%0d b_data", i), 32'(b_data), 32'(vecs[i].exp_bd));
    end

    // Both channels full: in_ready follows sw combinationally.
    @(negedge clk);
    in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0; sw = 1'b0;
    #1 check("full A sel ready", 32'(in_ready), 32'd0);
    sw = 1'b1;
    #1 check("full B sel ready", 32'(in_ready), 32'd0);

    // Async reset pulse between edges clears everything at once.
    #1 rst = 1'b1;
    #1;
    check("async a_valid", 32'(a_valid), 32'd0);
    check("async b_valid", 32'(b_valid), 32'd0);
    check("async a_data", 32'(a_data), 32'd0);
    check("async b_data", 32'(b_data), 32'd0);
    check("async in_ready B", 32'(in_ready), 32'd1);
    sw = 1'b0;
    #1 check("async in_ready A", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // After reset, a word pushed to B appears one edge later.
    @(negedge clk);
    sw = 1'b1; in_data = 4'hE; in_valid = 1'b1;
    #1 check("post-rst b_valid before edge", 32'(b_valid), 32'd0);
    @(posedge clk);
    #1;
    check("post-rst b_valid", 32'(b_valid), 32'd1);
    check("post-rst b_data", 32'(b_data), 32'hE);
    check("post-rst a_valid", 32'(a_valid), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
